// File: rtl/cnt_sweep_ctrl.sv
// Sweep sequencer for a WIDTH-bit up/down count register: runs lo->hi->lo
// for a latched number of round trips, with abort, reject and status pulses.
module cnt_sweep_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SW_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [SW_W-1:0]  i_sweeps,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [SW_W-1:0]  o_sweep_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [SW_W-1:0]  SW_ONE  = SW_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SW_W-1:0]  sweeps_q, sweeps_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [SW_W-1:0]  swc_q, swc_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [SW_W-1:0]  swc_inc;

  assign swc_inc = swc_q + SW_ONE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      cnt_q    <= '0;
      swc_q    <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
      cnt_q    <= cnt_d;
      swc_q    <= swc_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    sweeps_d = sweeps_q;
    cnt_d    = cnt_q;
    swc_d    = swc_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          if ((i_lo < i_hi) && (i_sweeps != '0)) begin
            lo_d     = i_lo;
            hi_d     = i_hi;
            sweeps_d = i_sweeps;
            cnt_d    = i_lo;
            swc_d    = '0;
            mode_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP: begin
        if (i_abort) begin
          mode_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == hi_q) begin
          // turn without dwell: hi is shown for exactly one cycle
          cnt_d   = hi_q - CNT_ONE;
          mode_d  = 1'b1;
          state_d = DOWN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DOWN: begin
        if (i_abort) begin
          mode_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != lo_q) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          swc_d = swc_inc;
          if (swc_inc == sweeps_q) begin
            mode_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = lo_q + CNT_ONE;
            mode_d  = 1'b0;
            state_d = UP;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_cnt       = cnt_q;
  assign o_mode      = mode_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_sweep_cnt = swc_q;

endmodule
